display_fetch_arbiter: RTL

- Sequences per-line framebuffer fetches for scanout and shares the single-port framebuffer memory with a draw engine.
- Sits between the display timing generator (frame/line/sy outputs) and the framebuffer RAM.
- Writes each fetched row into a ping-pong line buffer that scanout reads on the following line.
- Scanout fetch has absolute priority. The draw engine gets single-cycle accesses only while no fetch is in progress.

---
 rtl/display_fetch_arbiter_if.sv | 52 +++++
 rtl/display_fetch_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/display_fetch_arbiter_if.sv
// Bundles the display_fetch_arbiter signals: timing inputs, draw port,
// framebuffer port, line-buffer write port and status.
// slave = arbiter side, master = surrounding system / testbench side.
interface display_fetch_arbiter_if #(
    parameter int CORDW = 16,
    parameter int ADDRW = 19,
    parameter int DATAW = 8,
    parameter int LBAW  = 10
);
    // display timing
    logic                    frame;
    logic                    line;
    logic signed [CORDW-1:0] sy;
    // draw engine port
    logic                    draw_req;
    logic                    draw_we;
    logic [ADDRW-1:0]        draw_addr;
    logic [DATAW-1:0]        draw_wdata;
    logic                    draw_gnt;
    logic                    draw_rvalid;
    logic [DATAW-1:0]        draw_rdata;
    // framebuffer port
    logic [ADDRW-1:0]        mem_addr;
    logic                    mem_we;
    logic [DATAW-1:0]        mem_wdata;
    logic [DATAW-1:0]        mem_rdata;
    // line buffer port and status
    logic                    lb_we;
    logic [LBAW:0]           lb_addr;
    logic [DATAW-1:0]        lb_wdata;
    logic                    lb_sel;
    logic                    fetch_busy;
    logic                    underrun;

    modport slave (
        input  frame, line, sy,
        input  draw_req, draw_we, draw_addr, draw_wdata,
        output draw_gnt, draw_rvalid, draw_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output lb_we, lb_addr, lb_wdata, lb_sel, fetch_busy, underrun
    );

    modport master (
        output frame, line, sy,
        output draw_req, draw_we, draw_addr, draw_wdata,
        input  draw_gnt, draw_rvalid, draw_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  lb_we, lb_addr, lb_wdata, lb_sel, fetch_busy, underrun
    );
endinterface

// File: rtl/display_fetch_arbiter.sv
// Purpose: per-line framebuffer fetch into a ping-pong line buffer, sharing the RAM with a draw engine.
// Latency: trigger to first fetch address 1 cycle, to last lb_we LINE_W+1 cycles; draw read data 1 cycle after grant.
// Backpressure: fetch always wins; draw_req is held until draw_gnt, granted only in IDLE with no trigger.
//
// Ports: clk_pix/rst plain; bus (slave) carries frame/line/sy timing, the draw
// req/gnt/rdata port, the framebuffer address/data port and the line-buffer
// write port, plus lb_sel, fetch_busy and the sticky underrun flag.
module display_fetch_arbiter #(
    parameter int CORDW  = 16,
    parameter int V_RES  = 480,
    parameter int LINE_W = 640,
    parameter int ADDRW  = 19,
    parameter int DATAW  = 8,
    parameter int LBAW   = 10
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    display_fetch_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic signed [CORDW-1:0] SY_ZERO      = '0;
    localparam logic signed [CORDW-1:0] SY_LAST_TRIG = CORDW'(V_RES - 2);
    localparam logic [LBAW-1:0]         IDX_LAST     = LBAW'(LINE_W - 1);
    localparam logic [ADDRW-1:0]        ROW_STEP     = ADDRW'(LINE_W);

    logic [1:0]       state_q,     state_d;
    logic [LBAW-1:0]  idx_q,       idx_d;
    logic [LBAW-1:0]  idx_prev_q,  idx_prev_d;
    logic [ADDRW-1:0] row_base_q,  row_base_d;
    logic [ADDRW-1:0] next_base_q, next_base_d;
    logic             lb_sel_q,    lb_sel_d;
    logic             lb_we_q,     lb_we_d;
    logic             rvalid_q,    rvalid_d;
    logic             underrun_q,  underrun_d;

    logic signed [CORDW-1:0] sy_s;
    logic line_trig;
    logic trig;
    logic idle;
    logic fetching;
    logic gnt;

    assign sy_s      = bus.sy;
    // The last active line has no successor row to prefetch.
    assign line_trig = bus.line && (sy_s >= SY_ZERO) && (sy_s <= SY_LAST_TRIG);
    assign trig      = bus.frame | line_trig;
    assign idle      = (state_q == S_IDLE);
    assign fetching  = (state_q == S_FETCH);
    // Gated by rst so every output reads 0 the moment reset is applied.
    assign gnt       = bus.draw_req & idle & ~trig & ~rst;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idx_prev_d  = idx_q;
        row_base_d  = row_base_q;
        next_base_d = next_base_q;
        lb_sel_d    = lb_sel_q;
        underrun_d  = underrun_q;
        // Each fetch read returns data next cycle, which goes straight to the line buffer.
        lb_we_d     = fetching;
        rvalid_d    = gnt & ~bus.draw_we;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d  = S_FETCH;
                    idx_d    = '0;
                    lb_sel_d = ~lb_sel_q;
                    if (bus.frame) begin
                        // Frame restarts the row walk: row 0 at base 0, row 1 follows at LINE_W.
                        row_base_d  = '0;
                        next_base_d = ROW_STEP;
                    end else begin
                        row_base_d  = next_base_q;
                        next_base_d = next_base_q + ROW_STEP;
                    end
                end
            end
            S_FETCH: begin
                idx_d = idx_q + LBAW'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end
                if (trig) begin
                    underrun_d = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                if (trig) begin
                    underrun_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            idx_prev_q  <= '0;
            row_base_q  <= '0;
            next_base_q <= '0;
            lb_sel_q    <= 1'b0;
            lb_we_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idx_prev_q  <= idx_prev_d;
            row_base_q  <= row_base_d;
            next_base_q <= next_base_d;
            lb_sel_q    <= lb_sel_d;
            lb_we_q     <= lb_we_d;
            rvalid_q    <= rvalid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (fetching) begin
            bus.mem_addr = row_base_q + ADDRW'(idx_q);
        end else if (gnt) begin
            bus.mem_addr  = bus.draw_addr;
            bus.mem_we    = bus.draw_we;
            bus.mem_wdata = bus.draw_we ? bus.draw_wdata : DATAW'(0);
        end
    end

    // Fill half is the opposite of the half scanout is reading.
    assign bus.lb_we       = lb_we_q;
    assign bus.lb_addr     = lb_we_q ? {~lb_sel_q, idx_prev_q} : '0;
    assign bus.lb_wdata    = lb_we_q ? bus.mem_rdata : DATAW'(0);
    assign bus.lb_sel      = lb_sel_q;
    assign bus.fetch_busy  = ~idle;
    assign bus.underrun    = underrun_q;
    assign bus.draw_gnt    = gnt;
    assign bus.draw_rvalid = rvalid_q;
    assign bus.draw_rdata  = rvalid_q ? bus.mem_rdata : DATAW'(0);

endmodule
